// File: rtl/acc_alu.sv
// acc_alu: two-stage pipelined add/subtract unit with internal accumulator,
// optional unsigned saturation, carry/overflow flags and a completed-op counter.
module acc_alu #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       op,
  input  logic             sat_en,
  input  logic             clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned MSB = WIDTH - 1;

  // Stage 1 registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [1:0]       s1_op;
  logic             s1_sat;

  // Accumulator, written only by stage 2
  logic [WIDTH-1:0] acc;

  // Stage 2 datapath
  logic             is_sub;
  logic             use_acc;
  logic [WIDTH-1:0] opnd_x;
  logic [WIDTH-1:0] opnd_y;
  logic [WIDTH:0]   raw;
  logic             raw_carry;
  logic             raw_ovf;
  logic [WIDTH-1:0] next_res;

  // Stage 2 arithmetic: op[0] selects subtract, op[1] selects the accumulator as first operand
  always_comb begin
    is_sub    = s1_op[0];
    use_acc   = s1_op[1];
    opnd_x    = use_acc ? acc  : s1_a;
    opnd_y    = use_acc ? s1_a : s1_b;
    raw       = '0;
    raw_ovf   = 1'b0;
    if (is_sub) begin
      raw     = {1'b0, opnd_x} - {1'b0, opnd_y};
      raw_ovf = (opnd_x[MSB] != opnd_y[MSB]) && (raw[MSB] != opnd_x[MSB]);
    end else begin
      raw     = {1'b0, opnd_x} + {1'b0, opnd_y};
      raw_ovf = (opnd_x[MSB] == opnd_y[MSB]) && (raw[MSB] != opnd_x[MSB]);
    end
    // Bit WIDTH of the zero-extended difference is set exactly when x < y, i.e. a borrow
    raw_carry = raw[WIDTH];
    next_res  = raw[WIDTH-1:0];
    if (s1_sat && raw_carry) begin
      next_res = is_sub ? '0 : '1;
    end
  end

  // Pipeline, accumulator and output registers; clr flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= '0;
      s1_sat    <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      count     <= '0;
    end else if (clr) begin
      s1_valid  <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      ovf       <= 1'b0;
      count     <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_op  <= op;
        s1_sat <= sat_en;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= next_res;
        carry  <= raw_carry;
        ovf    <= raw_ovf;
        acc    <= next_res;
        count  <= count + CNT_W'(1);
      end
    end
  end

endmodule
